// File: rtl/rgb_layer_mux_if.sv
// Pixel-side bundle for rgb_layer_mux: timing coordinates, layer colours and
// draw requests in; RGB levels, frame pulse and collision report out.
interface rgb_layer_mux_if;
    logic [31:0] pxl_x;
    logic [31:0] pxl_y;
    logic [3:0]  layer_dr;
    logic [47:0] layer_rgb;
    logic [11:0] bg_rgb;
    logic [3:0]  Red_level;
    logic [3:0]  Green_level;
    logic [3:0]  Blue_level;
    logic        frame_start;
    logic [5:0]  coll_frame;
    logic        coll_valid;

    modport master (
        output pxl_x, pxl_y, layer_dr, layer_rgb, bg_rgb,
        input  Red_level, Green_level, Blue_level, frame_start, coll_frame, coll_valid
    );

    modport slave (
        input  pxl_x, pxl_y, layer_dr, layer_rgb, bg_rgb,
        output Red_level, Green_level, Blue_level, frame_start, coll_frame, coll_valid
    );
endinterface

// File: rtl/rgb_layer_mux.sv
// Priority layer mux with LAT-deep colour pipeline, frame-start pulse and
// per-frame pairwise collision report (enabled by RGB_LAYER_MUX_COLL_EN).
module rgb_layer_mux #(
    parameter int unsigned LAT   = 2,
    parameter int unsigned H_VIS = 640,
    parameter int unsigned V_VIS = 480
) (
    input  logic            clk_25,
    input  logic            resetN,
    rgb_layer_mux_if.slave  bus
);

    logic [11:0] w_sel;
    logic        w_found;
    logic [11:0] r_pipe [LAT];
    logic        w_origin;
    logic        w_rise;
    logic        r_origin_q;
    logic        r_frame_start;

    // Lowest-index requesting layer wins; background when nobody draws.
    always_comb begin
        w_sel   = bus.bg_rgb;
        w_found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!w_found && bus.layer_dr[i]) begin
                w_sel   = bus.layer_rgb[12*i +: 12];
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_sel;
            for (int unsigned i = 1; i < LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign {bus.Red_level, bus.Green_level, bus.Blue_level} = r_pipe[LAT-1];

    assign w_origin = (bus.pxl_x == '0) && (bus.pxl_y == '0);
    assign w_rise   = w_origin && !r_origin_q;

    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            r_origin_q    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_origin_q    <= w_origin;
            r_frame_start <= w_rise;
        end
    end

    assign bus.frame_start = r_frame_start;

`ifdef RGB_LAYER_MUX_COLL_EN
    logic       w_visible;
    logic [5:0] w_pairs;
    logic [5:0] r_coll_acc;
    logic [5:0] r_coll_frame;
    logic       r_coll_valid;

    assign w_visible = (bus.pxl_x < H_VIS) && (bus.pxl_y < V_VIS);

    always_comb begin
        w_pairs = '0;
        if (w_visible) begin
            w_pairs[0] = bus.layer_dr[0] & bus.layer_dr[1];
            w_pairs[1] = bus.layer_dr[0] & bus.layer_dr[2];
            w_pairs[2] = bus.layer_dr[0] & bus.layer_dr[3];
            w_pairs[3] = bus.layer_dr[1] & bus.layer_dr[2];
            w_pairs[4] = bus.layer_dr[1] & bus.layer_dr[3];
            w_pairs[5] = bus.layer_dr[2] & bus.layer_dr[3];
        end
    end

    // The origin pixel seeds the new accumulator so its own overlap is kept.
    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            r_coll_acc   <= '0;
            r_coll_frame <= '0;
            r_coll_valid <= 1'b0;
        end else begin
            r_coll_valid <= w_rise;
            if (w_rise) begin
                r_coll_frame <= r_coll_acc;
                r_coll_acc   <= w_pairs;
            end else begin
                r_coll_acc   <= r_coll_acc | w_pairs;
            end
        end
    end

    assign bus.coll_frame = r_coll_frame;
    assign bus.coll_valid = r_coll_valid;
`else
    assign bus.coll_frame = '0;
    assign bus.coll_valid = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_layer_mux.sv
// Scoreboard bench for rgb_layer_mux: three instances (LAT=1,2,4) share one
// stimulus stream; collision expectations follow RGB_LAYER_MUX_COLL_EN.
module tb_rgb_layer_mux;

`ifdef RGB_LAYER_MUX_COLL_EN
    localparam bit COLL = 1'b1;
`else
    localparam bit COLL = 1'b0;
`endif

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [3:0]  dr;
        logic        rst;
    } pix_t;

    typedef struct {
        logic [3:0]  dr;
        logic [47:0] rgb;
        logic [11:0] bg;
    } col_t;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    rgb_layer_mux_if if1 ();
    rgb_layer_mux_if if2 ();
    rgb_layer_mux_if if4 ();

    rgb_layer_mux #(.LAT(1)) u_lat1 (.clk_25(clk), .resetN(resetN), .bus(if1));
    rgb_layer_mux #(.LAT(2)) u_lat2 (.clk_25(clk), .resetN(resetN), .bus(if2));
    rgb_layer_mux #(.LAT(4)) u_lat4 (.clk_25(clk), .resetN(resetN), .bus(if4));

    logic [11:0] out_rgb [3];
    logic        out_fs  [3];
    logic        out_cv  [3];
    logic [5:0]  out_cf  [3];

    assign out_rgb[0] = {if1.Red_level, if1.Green_level, if1.Blue_level};
    assign out_rgb[1] = {if2.Red_level, if2.Green_level, if2.Blue_level};
    assign out_rgb[2] = {if4.Red_level, if4.Green_level, if4.Blue_level};
    assign out_fs[0] = if1.frame_start;
    assign out_fs[1] = if2.frame_start;
    assign out_fs[2] = if4.frame_start;
    assign out_cv[0] = if1.coll_valid;
    assign out_cv[1] = if2.coll_valid;
    assign out_cv[2] = if4.coll_valid;
    assign out_cf[0] = if1.coll_frame;
    assign out_cf[1] = if2.coll_frame;
    assign out_cf[2] = if4.coll_frame;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] q_rgb [$];
    logic [5:0]  q_cf  [$];
    logic        m_oq;
    logic [5:0]  m_acc;
    logic [5:0]  m_cf;

    function automatic int unsigned lat_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 2 : 4;
    endfunction

    function automatic logic [11:0] model_sel(input logic [3:0] dr, input logic [47:0] rgb,
                                              input logic [11:0] bg);
        casez (dr)
            4'b???1: return rgb[11:0];
            4'b??10: return rgb[23:12];
            4'b?100: return rgb[35:24];
            4'b1000: return rgb[47:36];
            default: return bg;
        endcase
    endfunction

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [3:0] dr,
                         input logic [47:0] rgb, input logic [11:0] bg);
        if1.pxl_x = x;  if2.pxl_x = x;  if4.pxl_x = x;
        if1.pxl_y = y;  if2.pxl_y = y;  if4.pxl_y = y;
        if1.layer_dr = dr;  if2.layer_dr = dr;  if4.layer_dr = dr;
        if1.layer_rgb = rgb;  if2.layer_rgb = rgb;  if4.layer_rgb = rgb;
        if1.bg_rgb = bg;  if2.bg_rgb = bg;  if4.bg_rgb = bg;
    endtask

    task automatic model_reset();
        m_oq  = 1'b0;
        m_acc = '0;
        m_cf  = '0;
        q_cf.delete();
        q_rgb.delete();
    endtask

    // Advances the collision/frame model by one sampled pixel.
    task automatic model_step(input logic [31:0] x, input logic [31:0] y, input logic [3:0] dr,
                              output logic efs, output logic ecv);
        logic       org;
        logic       vis;
        logic [5:0] p;
        org = (x == 32'd0) && (y == 32'd0);
        vis = (x < 32'd640) && (y < 32'd480);
        p = '0;
        if (vis) p = {dr[2] & dr[3], dr[1] & dr[3], dr[1] & dr[2],
                      dr[0] & dr[3], dr[0] & dr[2], dr[0] & dr[1]};
        efs = org && !m_oq;
        ecv = efs && COLL;
        if (efs) begin
            if (COLL) begin
                m_cf = m_acc;
                q_cf.push_back(m_acc);
            end
            m_acc = p;
        end else begin
            m_acc = m_acc | p;
        end
        m_oq = org;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        model_reset();
        drive(32'd0, 32'd0, 4'b1111, 48'hABC_DEF_123_456, 12'h789);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                n_checks++;
                if ({out_rgb[d], out_fs[d], out_cv[d], out_cf[d]} !== 20'h0) begin
                    n_fail++;
                    $display("FAIL reset lat%0d cycle %0d: got rgb=%h fs=%b cv=%b cf=%b want all 0",
                             lat_of(d), c, out_rgb[d], out_fs[d], out_cv[d], out_cf[d]);
                end
            end
        end
        resetN = 1'b1;
    endtask

    task automatic test_priority();
        col_t tab[$];
        logic [11:0] exp;
        do_reset();
        tab.push_back('{4'b0110, 48'h123_0F0_F00_0AA, 12'h00F});
        tab.push_back('{4'b0000, 48'h123_0F0_F00_0AA, 12'h00F});
        tab.push_back('{4'b1000, 48'h123_0F0_F00_0AA, 12'h00F});
        tab.push_back('{4'b1111, 48'h123_0F0_F00_0AA, 12'h00F});
        tab.push_back('{4'b1010, 48'h123_0F0_F00_0AA, 12'h00F});
        tab.push_back('{4'b0100, 48'h123_0F0_F00_0AA, 12'h00F});
        for (int i = 0; i < 8; i++)
            tab.push_back('{4'($urandom), {$urandom, 16'($urandom)}, 12'($urandom)});
        for (int i = 0; i < 4; i++)
            tab.push_back('{4'b0000, 48'h0, 12'h000});
        foreach (tab[i]) begin
            drive(32'd10 + 32'(i), 32'd10, tab[i].dr, tab[i].rgb, tab[i].bg);
            q_rgb.push_back(model_sel(tab[i].dr, tab[i].rgb, tab[i].bg));
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                exp = (q_rgb.size() >= lat_of(d)) ? q_rgb[q_rgb.size() - lat_of(d)] : 12'h000;
                n_checks++;
                if (out_rgb[d] !== exp) begin
                    n_fail++;
                    $display("FAIL priority rgb lat%0d step %0d: got %h want %h",
                             lat_of(d), i, out_rgb[d], exp);
                end
            end
            if (q_rgb.size() == 4) void'(q_rgb.pop_front());
        end
    endtask

    task automatic test_background();
        col_t tab[$];
        logic [11:0] exp;
        do_reset();
        for (int i = 0; i < 6; i++) tab.push_back('{4'b0000, {$urandom, 16'($urandom)}, 12'h5A3});
        for (int i = 0; i < 8; i++) tab.push_back('{4'b0000, {$urandom, 16'($urandom)}, 12'($urandom)});
        tab.push_back('{4'b0000, 48'hFFF_FFF_FFF_FFF, 12'h000});
        tab.push_back('{4'b0000, 48'h0, 12'hFFF});
        foreach (tab[i]) begin
            drive(32'd700, 32'd500, tab[i].dr, tab[i].rgb, tab[i].bg);
            q_rgb.push_back(model_sel(tab[i].dr, tab[i].rgb, tab[i].bg));
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                exp = (q_rgb.size() >= lat_of(d)) ? q_rgb[q_rgb.size() - lat_of(d)] : 12'h000;
                n_checks++;
                if (out_rgb[d] !== exp) begin
                    n_fail++;
                    $display("FAIL background rgb lat%0d step %0d: got %h want %h",
                             lat_of(d), i, out_rgb[d], exp);
                end
            end
            if (q_rgb.size() == 4) void'(q_rgb.pop_front());
        end
    endtask

    task automatic test_collision();
        pix_t tab[$];
        logic efs, ecv;
        logic [5:0] exp;
        do_reset();
        tab.push_back('{32'd5, 32'd5, 4'b0000, 1'b0});
        tab.push_back('{32'd0, 32'd0, 4'b0000, 1'b0});
        tab.push_back('{32'd100, 32'd50, 4'b1001, 1'b0});
        tab.push_back('{32'd700, 32'd10, 4'b0110, 1'b0});
        tab.push_back('{32'd200, 32'd20, 4'b0001, 1'b0});
        tab.push_back('{32'd300, 32'd30, 4'b0000, 1'b0});
        tab.push_back('{32'd0, 32'd0, 4'b0000, 1'b0});
        tab.push_back('{32'd1, 32'd0, 4'b0000, 1'b0});
        tab.push_back('{32'd639, 32'd479, 4'b0101, 1'b0});
        tab.push_back('{32'd640, 32'd5, 4'b1100, 1'b0});
        tab.push_back('{32'd5, 32'd480, 4'b1010, 1'b0});
        tab.push_back('{32'hFFFF_FFFF, 32'd3, 4'b0011, 1'b0});
        tab.push_back('{32'd3, 32'hFFFF_FFFF, 4'b1001, 1'b0});
        tab.push_back('{32'd0, 32'd0, 4'b0000, 1'b0});
        tab.push_back('{32'd1, 32'd0, 4'b0000, 1'b0});
        tab.push_back('{32'd2, 32'd0, 4'b0000, 1'b0});
        foreach (tab[i]) begin
            drive(tab[i].x, tab[i].y, tab[i].dr, 48'h123_456_789_ABC, 12'hDEF);
            model_step(tab[i].x, tab[i].y, tab[i].dr, efs, ecv);
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                n_checks++;
                if (out_fs[d] !== efs) begin
                    n_fail++;
                    $display("FAIL collision frame_start lat%0d step %0d: got %b want %b",
                             lat_of(d), i, out_fs[d], efs);
                end
            end
            n_checks++;
            if (out_cv[1] !== ecv) begin
                n_fail++;
                $display("FAIL collision coll_valid step %0d: got %b want %b", i, out_cv[1], ecv);
            end
            n_checks++;
            if (out_cf[1] !== m_cf) begin
                n_fail++;
                $display("FAIL collision coll_frame step %0d: got %b want %b", i, out_cf[1], m_cf);
            end
            if (out_cv[1] === 1'b1 && q_cf.size() != 0) begin
                exp = q_cf.pop_front();
                n_checks++;
                if (out_cf[1] !== exp) begin
                    n_fail++;
                    $display("FAIL collision report step %0d: got %b want %b", i, out_cf[1], exp);
                end
            end
        end
        n_checks++;
        if (q_cf.size() != 0) begin
            n_fail++;
            $display("FAIL collision reports pending: got %0d want 0", q_cf.size());
        end
    endtask

    task automatic test_origin_hold();
        pix_t tab[$];
        logic efs, ecv;
        logic [5:0] exp;
        int n_fs;
        do_reset();
        n_fs = 0;
        tab.push_back('{32'd5, 32'd5, 4'b0000, 1'b0});
        tab.push_back('{32'd0, 32'd0, 4'b0011, 1'b0});
        tab.push_back('{32'd0, 32'd0, 4'b0011, 1'b0});
        tab.push_back('{32'd0, 32'd0, 4'b0011, 1'b0});
        tab.push_back('{32'd10, 32'd10, 4'b0000, 1'b0});
        tab.push_back('{32'd11, 32'd10, 4'b0100, 1'b0});
        tab.push_back('{32'd0, 32'd0, 4'b0000, 1'b0});
        tab.push_back('{32'd1, 32'd0, 4'b0000, 1'b0});
        foreach (tab[i]) begin
            drive(tab[i].x, tab[i].y, tab[i].dr, 48'h111_222_333_444, 12'h555);
            model_step(tab[i].x, tab[i].y, tab[i].dr, efs, ecv);
            @(posedge clk);
            @(negedge clk);
            if (out_fs[1] === 1'b1) n_fs++;
            n_checks++;
            if (out_fs[1] !== efs) begin
                n_fail++;
                $display("FAIL hold frame_start step %0d: got %b want %b", i, out_fs[1], efs);
            end
            n_checks++;
            if (out_cv[1] !== ecv) begin
                n_fail++;
                $display("FAIL hold coll_valid step %0d: got %b want %b", i, out_cv[1], ecv);
            end
            n_checks++;
            if (out_cf[1] !== m_cf) begin
                n_fail++;
                $display("FAIL hold coll_frame step %0d: got %b want %b", i, out_cf[1], m_cf);
            end
            if (out_cv[1] === 1'b1 && q_cf.size() != 0) begin
                exp = q_cf.pop_front();
                n_checks++;
                if (out_cf[1] !== exp) begin
                    n_fail++;
                    $display("FAIL hold report step %0d: got %b want %b", i, out_cf[1], exp);
                end
            end
        end
        n_checks++;
        if (n_fs != 2) begin
            n_fail++;
            $display("FAIL hold frame_start count: got %0d want 2", n_fs);
        end
    endtask

    task automatic test_reset_mid();
        pix_t tab[$];
        logic efs, ecv;
        logic [5:0] exp;
        do_reset();
        tab.push_back('{32'd5, 32'd5, 4'b0000, 1'b0});
        tab.push_back('{32'd0, 32'd0, 4'b0000, 1'b0});
        tab.push_back('{32'd50, 32'd50, 4'b1111, 1'b0});
        tab.push_back('{32'd60, 32'd60, 4'b0011, 1'b0});
        tab.push_back('{32'd61, 32'd60, 4'b0110, 1'b1});
        tab.push_back('{32'd62, 32'd60, 4'b0110, 1'b1});
        tab.push_back('{32'd63, 32'd60, 4'b0000, 1'b0});
        tab.push_back('{32'd0, 32'd0, 4'b0000, 1'b0});
        tab.push_back('{32'd5, 32'd5, 4'b0001, 1'b0});
        tab.push_back('{32'd6, 32'd5, 4'b0100, 1'b0});
        tab.push_back('{32'd0, 32'd0, 4'b0000, 1'b0});
        tab.push_back('{32'd1, 32'd0, 4'b0000, 1'b0});
        foreach (tab[i]) begin
            drive(tab[i].x, tab[i].y, tab[i].dr, 48'hAAA_BBB_CCC_DDD, 12'hEEE);
            if (tab[i].rst) begin
                resetN = 1'b0;
                model_reset();
                efs = 1'b0;
                ecv = 1'b0;
            end else begin
                resetN = 1'b1;
                model_step(tab[i].x, tab[i].y, tab[i].dr, efs, ecv);
            end
            @(posedge clk);
            @(negedge clk);
            if (tab[i].rst) begin
                for (int d = 0; d < 3; d++) begin
                    n_checks++;
                    if ({out_rgb[d], out_fs[d], out_cv[d], out_cf[d]} !== 20'h0) begin
                        n_fail++;
                        $display("FAIL midreset outputs lat%0d step %0d: got rgb=%h fs=%b cv=%b cf=%b want all 0",
                                 lat_of(d), i, out_rgb[d], out_fs[d], out_cv[d], out_cf[d]);
                    end
                end
            end
            n_checks++;
            if (out_fs[1] !== efs || out_cv[1] !== ecv) begin
                n_fail++;
                $display("FAIL midreset pulses step %0d: got fs=%b cv=%b want fs=%b cv=%b",
                         i, out_fs[1], out_cv[1], efs, ecv);
            end
            n_checks++;
            if (out_cf[1] !== m_cf) begin
                n_fail++;
                $display("FAIL midreset coll_frame step %0d: got %b want %b", i, out_cf[1], m_cf);
            end
            if (out_cv[1] === 1'b1 && q_cf.size() != 0) begin
                exp = q_cf.pop_front();
                n_checks++;
                if (out_cf[1] !== exp) begin
                    n_fail++;
                    $display("FAIL midreset report step %0d: got %b want %b", i, out_cf[1], exp);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench did not finish");
    end

    initial begin
        test_reset();
        test_priority();
        test_background();
        test_collision();
        test_origin_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
